// File: rtl/time_seg_display_if.sv
// Time-update handshake between a time source and the seven-segment display block.
interface time_seg_display_if;
  logic [5:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       upd_valid;
  logic       upd_ready;

  modport master (output hours, minutes, seconds, upd_valid, input upd_ready);
  modport slave  (input hours, minutes, seconds, upd_valid, output upd_ready);
endinterface

// File: rtl/time_seg_display.sv
// Converts a captured hh:mm:ss to BCD by double-dabble and drives six active-low
// seven-segment digits; the hours/minutes ones digits carry a blinking colon dp.
module time_seg_display #(
  parameter int BLINK_HALF = 25000000
) (
  input  logic               clk,
  input  logic               rst,
  time_seg_display_if.slave  upd,
  output logic [7:0]         HEX00,
  output logic [7:0]         HEX01,
  output logic [7:0]         HEX02,
  output logic [7:0]         HEX03,
  output logic [7:0]         HEX04,
  output logic [7:0]         HEX05
);

  localparam int CW = $clog2(BLINK_HALF);
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, COMMIT = 2'd2} state_t;

  state_t          state_r, state_s;
  logic            ready_r;
  logic [2:0]      shift_cnt_r;
  logic [13:0]     hrs_r, min_r, sec_r;   // {tens, ones, binary} shift registers
  logic [2:0]      err_r;                 // {hours, minutes, seconds} out of range
  logic [6:0]      seg00_r, seg01_r, seg02_r, seg03_r, seg04_r, seg05_r;
  logic [CW-1:0]   blink_cnt_r;
  logic            phase_r;
  logic            dp_r;

  // One double-dabble step: +3 on BCD nibbles >= 5, then shift the whole word left.
  function automatic logic [13:0] dabble_step(input logic [13:0] v);
    logic [13:0] t;
    t = v;
    if (t[13:10] >= 4'd5) t[13:10] = t[13:10] + 4'd3;
    if (t[9:6]   >= 4'd5) t[9:6]   = t[9:6]   + 4'd3;
    return {t[12:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // Next-state logic of the IDLE/SHIFT/COMMIT sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (upd.upd_valid) state_s = SHIFT;
        else               state_s = IDLE;
      end
      SHIFT: begin
        if (shift_cnt_r == 3'd5) state_s = COMMIT;
        else                     state_s = SHIFT;
      end
      COMMIT:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register, shift counter and registered ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      shift_cnt_r <= 3'd0;
      ready_r     <= 1'b1;
    end else begin
      state_r     <= state_s;
      ready_r     <= (state_s == IDLE);
      if (state_r == SHIFT) shift_cnt_r <= shift_cnt_r + 3'd1;
      else                  shift_cnt_r <= 3'd0;
    end
  end

  // Capture, BCD conversion and segment commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hrs_r   <= 14'd0;
      min_r   <= 14'd0;
      sec_r   <= 14'd0;
      err_r   <= 3'd0;
      seg00_r <= 7'h7F;
      seg01_r <= 7'h7F;
      seg02_r <= 7'h7F;
      seg03_r <= 7'h7F;
      seg04_r <= 7'h7F;
      seg05_r <= 7'h7F;
    end else begin
      case (state_r)
        IDLE: begin
          if (upd.upd_valid) begin
            hrs_r <= {8'd0, upd.hours};
            min_r <= {8'd0, upd.minutes};
            sec_r <= {8'd0, upd.seconds};
            err_r <= {upd.hours > 6'd23, upd.minutes > 6'd59, upd.seconds > 6'd59};
          end
        end
        SHIFT: begin
          hrs_r <= dabble_step(hrs_r);
          min_r <= dabble_step(min_r);
          sec_r <= dabble_step(sec_r);
        end
        COMMIT: begin
          seg00_r <= err_r[2] ? 7'h3F : seg_enc(hrs_r[13:10]);
          seg01_r <= err_r[2] ? 7'h3F : seg_enc(hrs_r[9:6]);
          seg02_r <= err_r[1] ? 7'h3F : seg_enc(min_r[13:10]);
          seg03_r <= err_r[1] ? 7'h3F : seg_enc(min_r[9:6]);
          seg04_r <= err_r[0] ? 7'h3F : seg_enc(sec_r[13:10]);
          seg05_r <= err_r[0] ? 7'h3F : seg_enc(sec_r[9:6]);
        end
        default: begin
          hrs_r <= hrs_r;
        end
      endcase
    end
  end

  // Free-running colon blink; dp tracks the phase being entered so it changes on the wrap edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt_r <= '0;
      phase_r     <= 1'b0;
      dp_r        <= 1'b1;
    end else if (blink_cnt_r == BLINK_LAST) begin
      blink_cnt_r <= '0;
      phase_r     <= ~phase_r;
      dp_r        <= phase_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + CW'(1);
      dp_r        <= ~phase_r;
    end
  end

  assign upd.upd_ready = ready_r;
  assign HEX00 = {1'b1, seg00_r};
  assign HEX01 = {dp_r, seg01_r};
  assign HEX02 = {1'b1, seg02_r};
  assign HEX03 = {dp_r, seg03_r};
  assign HEX04 = {1'b1, seg04_r};
  assign HEX05 = {1'b1, seg05_r};

endmodule

// File: doc/time_seg_display.md
TIME_SEG_DISPLAY -- requirements
Module: time_seg_display

Interface
REQ-001 Parameter BLINK_HALF, default 25000000, is the number of clk cycles per half-period of the colon blink; legal range is at least 2.
REQ-002 clk  input  1  rising-edge system clock (50 MHz).
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 hours  input  6  binary hours; legal range 0-23.
REQ-005 minutes  input  6  binary minutes; legal range 0-59.
REQ-006 seconds  input  6  binary seconds; legal range 0-59.
REQ-007 upd_valid  input  1  time-update request; the source SHALL hold it and the data stable until accepted.
REQ-008 upd_ready  output  1  block can accept an update; high only in IDLE.
REQ-009 HEX00, HEX01  output  8 each  hours tens / hours ones.
REQ-010 HEX02, HEX03  output  8 each  minutes tens / minutes ones.
REQ-011 HEX04, HEX05  output  8 each  seconds tens / seconds ones.
REQ-012 Each HEXnn SHALL be registered and active-low, with bit7 = dp and bits[6:0] = g,f,e,d,c,b,a; a 0 bit lights the segment.

Function
REQ-013 Acceptance SHALL occur on a rising edge where upd_valid=1 and upd_ready=1; hours, minutes and seconds are captured on that edge.
REQ-014 The FSM SHALL have three states: IDLE, SHIFT and COMMIT.
REQ-015 IDLE SHALL go to SHIFT on acceptance (shift count=0); otherwise it stays in IDLE.
REQ-016 SHIFT SHALL run exactly 6 cycles, then go to COMMIT.
REQ-017 COMMIT SHALL take 1 cycle, then return to IDLE.
REQ-018 In SHIFT, each edge SHALL run one double-dabble step on all three fields in parallel (add 3 to any BCD nibble >=5, then shift left 1, MSB first); after 6 steps each field holds tens[3:0] and ones[3:0].
REQ-019 On the COMMIT edge, all six HEX segment fields SHALL update simultaneously; outputs change on the 7th edge after the acceptance edge.
REQ-020 Maximum throughput SHALL be one update per 8 cycles; upd_ready is 0 in SHIFT and COMMIT.
REQ-021 upd_valid asserted while busy SHALL be ignored, with no queuing; input changes after acceptance SHALL not affect the conversion in progress.
REQ-022 Digit encodings [6:0] SHALL be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
REQ-023 Range check on captured values: hours>23, minutes>59 or seconds>59 SHALL make both digits of that field show a dash ([6:0]=3F); the other fields are unaffected.
REQ-024 A leading zero SHALL be displayed, not blanked (e.g. 7 shows "07").
REQ-025 A free-running blink counter SHALL count 0..BLINK_HALF-1 and toggle phase on wrap; it runs in every FSM state.
REQ-026 The dp bit of HEX01 and HEX03 SHALL be the inverse of phase (dp lit while phase=1) and SHALL update every cycle, independently of COMMIT; the dp of all other digits is always 1.

Reset
REQ-027 While rst=0, the block SHALL be in IDLE with shift count 0, blink counter 0, phase 0, upd_ready=1 and every HEXnn=FF (blank).
REQ-028 Reset asserted in SHIFT or COMMIT SHALL abort the conversion with no output update; the first acceptance is possible on the first edge after rst deasserts.

Verification
REQ-029 After reset, apply 23:59:07 with upd_valid=1 -> after 7 edges HEX00..HEX05 = A4,B0,92,90,C0,F8 (phase 0); upd_ready is low for exactly 7 cycles.
REQ-030 Apply 00:00:00, then after commit apply 12:34:56 -> first C0,C0,C0,C0,C0,C0, then F9,A4,B0,99,92,82.
REQ-031 Apply hours=30, minutes=5, seconds=60 -> HEX00/01=BF, HEX02/03=C0/92, HEX04/05=BF.
REQ-032 Change inputs and pulse upd_valid during SHIFT -> the original value is committed, no second conversion starts, and upd_ready returns after COMMIT.
REQ-033 Assert rst during SHIFT cycle 3 -> all HEX=FF and upd_ready=1 immediately; the next accepted update converts correctly.
REQ-034 With BLINK_HALF=4, hold idle -> HEX01/HEX03 bit7 toggles every 4 cycles (first low after 4 edges) while all other bits stay constant.
